// File: rtl/alu_cmd_ctrl_if.sv
// Command and response channels between upstream logic and alu_cmd_ctrl.
// Both channels are valid/ready: a transfer happens on a rising edge where valid && ready; once valid is high the payload holds until that transfer.
interface alu_cmd_ctrl_if #(
  parameter int W = 8
);
  logic           cmd_valid;
  logic           cmd_ready;
  logic [W-1:0]   cmd_a;
  logic [W-1:0]   cmd_b;
  logic [1:0]     cmd_op;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [2*W-1:0] rsp_result;
  logic           rsp_error;
  logic [1:0]     rsp_op;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_error, rsp_op
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_error, rsp_op
  );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// Queues ALU commands in a small FIFO, issues them one at a time to a combinational ALU,
// and returns registered results in command order with a saturating error count.
module alu_cmd_ctrl #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  alu_cmd_ctrl_if.slave    bus,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [1:0]       alu_op,
  input  logic [2*W-1:0]   alu_result,
  input  logic             alu_error,
  output logic [7:0]       err_count,
  output logic             busy,
  output logic [1:0]       dbg_state
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [2*W+1:0] mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic           full, empty, push, load, capture;
  logic [2*W+1:0] head;

  // full comes straight from the registered occupancy, so a same-cycle pop never frees a slot early
  assign full          = (count == (AW+1)'(DEPTH));
  assign empty         = (count == '0);
  assign bus.cmd_ready = !full;
  assign push          = bus.cmd_valid && !full;
  assign head          = mem[rd_ptr];
  assign busy          = (state != IDLE) || !empty;
  assign dbg_state     = state;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.cmd_op, bus.cmd_b, bus.cmd_a};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
      case ({push, load})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          load      = 1'b1;
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        capture   = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          if (!empty) begin
            load      = 1'b1;
            state_nxt = DRIVE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ALU operands are only rewritten on a load; the response fields only on capture
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a          <= '0;
      alu_b          <= '0;
      alu_op         <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_error  <= 1'b0;
      bus.rsp_op     <= '0;
      err_count      <= '0;
    end else begin
      if (load) begin
        alu_a      <= head[W-1:0];
        alu_b      <= head[2*W-1:W];
        alu_op     <= head[2*W+1:2*W];
        bus.rsp_op <= head[2*W+1:2*W];
      end
      if (capture) begin
        bus.rsp_valid  <= 1'b1;
        bus.rsp_result <= alu_result;
        bus.rsp_error  <= alu_error;
        if (alu_error && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
      end else if ((state == RESP) && bus.rsp_ready) begin
        bus.rsp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/alu_cmd_ctrl.md
Name: alu_cmd_ctrl

Overview:
Command-side controller that drives the combinational `alu` operand port (a, b, op) and collects its result (result, error). Upstream logic queues ALU commands through a valid/ready interface into a small FIFO. The block issues each command to the ALU, registers the ALU output, and returns it in order on a valid/ready response interface. It also keeps a saturating count of ALU error events.

Parameters:
DEPTH, 4, command FIFO entries; power of 2, minimum 2
W, 8, operand width; ALU result width is 2*W

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept a command (= !full)
cmd_a  input  W  operand a
cmd_b  input  W  operand b
cmd_op  input  2  00 add, 01 sub, 10 mul, 11 div
alu_a  output  W  registered operand to ALU
alu_b  output  W  registered operand to ALU
alu_op  output  2  registered opcode to ALU
alu_result  input  2W  combinational ALU result
alu_error  input  1  ALU error flag (divide by zero)
rsp_valid  output  1  response available
rsp_ready  input  1  consumer accepts response
rsp_result  output  2W  captured result
rsp_error  output  1  captured error flag
rsp_op  output  2  opcode of this response
err_count  output  8  saturating count of captured errors
busy  output  1  high when state != IDLE or FIFO not empty

Behaviour:
- Reset values: all outputs are 0 except cmd_ready, which is 1. FIFO is emptied, state is IDLE, and rst takes priority over every other event.
- Reset mid-operation: the in-flight command and any pending response are dropped without a handshake. err_count clears.
- Push: occurs on `cmd_valid && cmd_ready`.
  - cmd_ready is derived from registered full only.
  - No push is accepted while full, even in a cycle where a pop happens.
- Pop: occurs only on the FSM load described below. Push and pop in the same cycle are legal when not full; count is unchanged.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. A separate occupancy counter (0..DEPTH) drives full/empty.
- FSM:
  - IDLE: if FIFO not empty, load the head into alu_a/alu_b/alu_op and rsp_op, pop, and go to DRIVE. Otherwise stay.
  - DRIVE: the ALU output is settled. Capture alu_result into rsp_result and alu_error into rsp_error, set rsp_valid=1, and go to RESP. If alu_error, increment err_count, saturating at 255.
  - RESP: hold rsp_valid and all rsp_* stable until rsp_ready.
    - On rsp_ready with FIFO not empty: clear rsp_valid, load and pop the next head, go to DRIVE.
    - On rsp_ready with FIFO empty: clear rsp_valid, go to IDLE.
- alu_a/alu_b/alu_op hold their last value outside a load; they do not return to 0.
- Latency: a command pushed at edge N into an empty FIFO with the FSM in IDLE is loaded at N+1. rsp_valid is high after edge N+2, i.e. 2 cycles.
- Throughput: at most one response per 2 cycles.
- Responses are returned strictly in command order.
- No arithmetic in this block: result and error pass through from the ALU unmodified, including the ALU's error reporting for op=11 with b=0.

Test Plan:
1. Accept sequence: a=10, b=20, op=00, rsp_ready=1 -> rsp_valid 2 cycles after acceptance; rsp_result=30, rsp_error=0, rsp_op=00; busy returns to 0 the cycle after the handshake.
2. Back-to-back ops: push {30,15,01}, {5,3,10}, {40,8,11} on consecutive cycles -> responses in order 15, 15, 5, spaced 2 cycles apart.
3. Divide by zero: a=40, b=0, op=11 -> rsp_error=1, err_count=1. A following {40,8,11} gives rsp_error=0, rsp_result=5, err_count still 1.
4. Backpressure with rsp_ready=0:
   - Push 6 commands: commands 1-5 are accepted (1 in RESP, 4 in FIFO), then cmd_ready=0 and command 6 stalls.
   - rsp_valid and rsp_result stay stable.
   - Raising rsp_ready drains all responses in order; cmd_ready reasserts after the first pop.
5. Reset mid-RESP: with rsp_valid=1 and 2 commands queued, assert rst for 1 cycle -> next cycle rsp_valid=0, busy=0, cmd_ready=1, err_count=0. The queued commands never appear on the response interface.
6. err_count saturation: 260 divide-by-zero commands -> err_count stops at 255 and never wraps.
